rr_arb_mux4_stage: RTL and testbench

//   Round-robin arbitration stage ahead of the 4:1 data mux (mux_4_1). It accepts

---
 rtl/arb_pkg.sv | 17 +
 rtl/mux_4_1.sv | 22 ++
 rtl/rr_arbiter4.sv | 29 ++
 rtl/rr_arb_mux4_stage.sv | 88 ++++++++
 tb/tb_rr_arb_mux4_stage.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared types for the round-robin arbitration stage in front of the 4:1 mux.
// Latency: none (types only). Backpressure: none (types only).
package arb_pkg;
    localparam int N_CH = 4;

    typedef logic [1:0] ch_idx_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } oreg_state_t;

    // Pointer advance past the granted channel; 2-bit arithmetic wraps 3 -> 0.
    function automatic ch_idx_t next_ptr(input ch_idx_t g);
        return g + ch_idx_t'(1);
    endfunction
endpackage

// File: rtl/mux_4_1.sv
// Behavioural 4:1 word mux; only the selected input reaches the output.
// Latency: combinational. Backpressure: none.
module mux_4_1 #(
    parameter int W = 4
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic [W-1:0] y
);
    always_comb begin
        y = '0;
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end
endmodule

// File: rtl/rr_arbiter4.sv
// Rotating-priority 4-way arbiter: first request found scanning from ptr upward.
// Latency: combinational. Backpressure: caller gates the grant with its own load enable.
module rr_arbiter4
    import arb_pkg::*;
(
    input  logic [3:0] req,
    input  ch_idx_t    ptr,
    output logic [3:0] gnt_onehot,
    output ch_idx_t    gnt_idx,
    output logic       any_gnt
);
    ch_idx_t cand;

    // Scan from farthest to nearest so the nearest requester is written last and wins.
    always_comb begin
        gnt_idx = '0;
        any_gnt = 1'b0;
        cand    = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            cand = ptr + ch_idx_t'(k);
            if (req[cand]) begin
                gnt_idx = cand;
                any_gnt = 1'b1;
            end
        end
    end

    assign gnt_onehot = any_gnt ? (4'b0001 << gnt_idx) : 4'b0000;
endmodule

// File: rtl/rr_arb_mux4_stage.sv
// Round-robin pick of one of four valid/ready lanes into a single registered output.
// Latency: accept in cycle N -> word on out_data in cycle N+1; 1 word/cycle sustained.
// Backpressure: out_ready low while full freezes data/src/ptr and drops all in_ready.
module rr_arb_mux4_stage
    import arb_pkg::*;
#(
    parameter int W       = 4,
    parameter int RST_PTR = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   in_valid,
    output logic [3:0]   in_ready,
    input  logic [W-1:0] in_data0,
    input  logic [W-1:0] in_data1,
    input  logic [W-1:0] in_data2,
    input  logic [W-1:0] in_data3,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_src
);
    oreg_state_t state, state_nxt;
    ch_idx_t     ptr;
    ch_idx_t     gnt_idx;
    logic [3:0]  gnt_onehot;
    logic        any_gnt;
    logic        can_load;
    logic        load_ok;
    logic        load;
    logic [W-1:0] sel_data;

    rr_arbiter4 u_arb (
        .req        (in_valid),
        .ptr        (ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any_gnt    (any_gnt)
    );

    mux_4_1 #(.W(W)) u_mux (
        .sel (gnt_idx),
        .d0  (in_data0),
        .d1  (in_data1),
        .d2  (in_data2),
        .d3  (in_data3),
        .y   (sel_data)
    );

    // rst gates the handshake so nothing is accepted while the stage is being cleared.
    assign can_load = !out_valid || out_ready;
    assign load_ok  = can_load && !rst;
    assign load     = any_gnt && load_ok;
    assign in_ready = gnt_onehot & {4{load_ok}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   state_nxt = load ? FULL : EMPTY;
            FULL:    state_nxt = (out_ready && !load) ? EMPTY : FULL;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state == FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            out_src  <= '0;
            ptr      <= ch_idx_t'(RST_PTR);
        end else if (load) begin
            out_data <= sel_data;
            out_src  <= gnt_idx;
            ptr      <= next_ptr(gnt_idx);
        end
    end
endmodule

// File: tb/tb_rr_arb_mux4_stage.sv
// Scoreboard bench: driver predicts grants from a rotating-priority model, monitor checks words.
module tb_rr_arb_mux4_stage;
    localparam int W       = 4;
    localparam int RST_PTR = 0;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   in_valid = '0;
    logic [3:0]   in_ready;
    logic [W-1:0] in_data0 = '0, in_data1 = '0, in_data2 = '0, in_data3 = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [1:0]   out_src;

    int errors = 0;
    int checks = 0;

    // Reference model: occupancy of the output register and the next-highest-priority lane.
    int m_ptr  = RST_PTR;
    bit m_full = 1'b0;
    logic [W+1:0] exp_q[$];

    rr_arb_mux4_stage #(.W(W), .RST_PTR(RST_PTR)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: apply inputs after the falling edge, then check handshake against the model.
    task automatic drive(input logic [3:0] v, input logic r,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] d);
        logic [W-1:0] dat[4];
        int g;
        int ch;
        @(negedge clk);
        #1;
        in_valid = v; out_ready = r;
        in_data0 = a; in_data1 = b; in_data2 = c; in_data3 = d;
        dat[0] = a; dat[1] = b; dat[2] = c; dat[3] = d;
        #1;
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_full});
        g = -1;
        if (!m_full || r) begin
            for (int k = 0; k < 4; k++) begin
                ch = (m_ptr + k) % 4;
                if (g < 0 && v[ch]) g = ch;
            end
        end
        chk("in_ready", {28'b0, in_ready}, (g >= 0) ? (32'd1 << g) : 32'd0);
        if (g >= 0) begin
            exp_q.push_back({dat[g], 2'(g)});
            m_ptr  = (g + 1) % 4;
            m_full = 1'b1;
        end else if (r) begin
            m_full = 1'b0;
        end
    endtask

    // Monitor: a word that will transfer at the coming edge must match the oldest prediction.
    initial begin
        logic [W+1:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {26'b0, out_data, out_src}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", {28'b0, out_data}, {28'b0, e[W+1:2]});
                    chk("out_src",  {30'b0, out_src},  {30'b0, e[1:0]});
                end
            end
        end
    end

    task automatic async_reset();
        @(negedge clk);
        #4;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data",  {28'b0, out_data}, 32'd0);
        chk("rst_out_src",   {30'b0, out_src}, 32'd0);
        chk("rst_in_ready",  {28'b0, in_ready}, 32'd0);
        exp_q.delete();
        m_full = 1'b0;
        m_ptr  = RST_PTR;
        @(negedge clk);
        #4;
        rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] xv;
        xv = 'x;
        repeat (2) @(negedge clk);
        #4 rst = 1'b0;

        // All lanes valid: src 0,1,2,3,0 with data a,b,c,d,a.
        repeat (5) drive(4'b1111, 1'b1, 4'hA, 4'hB, 4'hC, 4'hD);
        drive(4'b0000, 1'b1, 0, 0, 0, 0);

        // Reset while full with data 5, then first grant from RST_PTR.
        drive(4'b0001, 1'b0, 4'h5, 0, 0, 0);
        drive(4'b0000, 1'b0, 0, 0, 0, 0);
        chk("full_before_rst", {28'b0, out_data}, 32'd5);
        async_reset();
        drive(4'b1111, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4);
        drive(4'b0000, 1'b1, 0, 0, 0, 0);
        async_reset();

        // Sparse requesters 1010 from ptr 0: ch1, ch3, ch1.
        repeat (3) drive(4'b1010, 1'b1, 0, 4'h6, 0, 4'hE);

        // Load ch2 with 7, stall three cycles, then ch0 reloads with no bubble.
        drive(4'b0100, 1'b1, 0, 0, 4'h7, 0);
        repeat (3) begin
            drive(4'b0001, 1'b0, 4'h8, 0, 0, 0);
            chk("stall_data", {28'b0, out_data}, 32'd7);
            chk("stall_src",  {30'b0, out_src}, 32'd2);
        end
        drive(4'b0001, 1'b1, 4'h8, 0, 0, 0);

        // Unknown data on an unselected lane stays off the output.
        drive(4'b0001, 1'b1, 4'h9, xv, xv, xv);

        // Drain to empty.
        drive(4'b0000, 1'b1, 0, 0, 0, 0);
        drive(4'b0000, 1'b1, 0, 0, 0, 0);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 2000; i++) begin
            drive(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                  W'($urandom), W'($urandom), W'($urandom), W'($urandom));
        end
        repeat (3) drive(4'b0000, 1'b1, 0, 0, 0, 0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
